// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: classifies the instruction's immediate format,
// builds the XLEN-wide immediate and hands it downstream over valid/ready with an optional skid entry.
module imm_gen_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TAG_W   = 8,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_Z     = 3'd6;
  localparam logic [2:0] FMT_SHAMT = 3'd7;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_FENCE    = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic            is_shift;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  assign opc      = in_instr[6:0];
  assign f3       = in_instr[14:12];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

  // Illegal encodings always report fmt NONE with a zero immediate.
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (opc)
      OPC_OP_IMM: begin
        if (!is_shift) begin
          dec_fmt = FMT_I;
          dec_imm = imm_i;
        end else if (XLEN == 32 && in_instr[25]) begin
          dec_ill = 1'b1;
        end else begin
          dec_fmt = FMT_SHAMT;
          dec_imm = (XLEN == 32) ? XLEN'(in_instr[24:20]) : XLEN'(in_instr[25:20]);
        end
      end
      OPC_OP_IMM32: begin
        if (XLEN == 32) begin
          dec_ill = 1'b1;
        end else if (is_shift) begin
          dec_fmt = FMT_SHAMT;
          dec_imm = XLEN'(in_instr[24:20]);
        end else begin
          dec_fmt = FMT_I;
          dec_imm = imm_i;
        end
      end
      OPC_LOAD, OPC_JALR: begin
        dec_fmt = FMT_I;
        dec_imm = imm_i;
      end
      OPC_STORE: begin
        dec_fmt = FMT_S;
        dec_imm = imm_s;
      end
      OPC_BRANCH: begin
        dec_fmt = FMT_B;
        dec_imm = imm_b;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_fmt = FMT_U;
        dec_imm = imm_u;
      end
      OPC_JAL: begin
        dec_fmt = FMT_J;
        dec_imm = imm_j;
      end
      OPC_SYSTEM: begin
        if (f3 == 3'b100) begin
          dec_ill = 1'b1;
        end else if (f3[2]) begin
          dec_fmt = FMT_Z;
          dec_imm = XLEN'(in_instr[19:15]);
        end else if (f3 != 3'b000) begin
          dec_fmt = FMT_I;
          dec_imm = XLEN'(in_instr[31:20]);
        end
      end
      OPC_OP, OPC_FENCE: ;
      OPC_OP32: dec_ill = (XLEN == 32);
      default: dec_ill = 1'b1;
    endcase
  end

  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q,   main_imm_d;
  logic [2:0]       main_fmt_q,   main_fmt_d;
  logic             main_ill_q,   main_ill_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [2:0]       skid_fmt_q,   skid_fmt_d;
  logic             skid_ill_q,   skid_ill_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             in_ready_q,   in_ready_d;
  logic             accept, xfer, main_free;

  assign in_ready  = SKID_EN ? in_ready_q : (!main_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign xfer      = main_valid_q && out_ready;
  assign main_free = !main_valid_q || out_ready;

  // Skid drains into main before main accepts new input; in_ready tracks skid occupancy.
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_fmt_d   = main_fmt_q;
    main_ill_d   = main_ill_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_ill_d   = skid_ill_q;
    skid_tag_d   = skid_tag_q;
    in_ready_d   = in_ready_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      in_ready_d   = 1'b1;
    end else begin
      if (xfer && skid_valid_q) begin
        main_valid_d = 1'b1;
        main_imm_d   = skid_imm_q;
        main_fmt_d   = skid_fmt_q;
        main_ill_d   = skid_ill_q;
        main_tag_d   = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (main_free) begin
        main_valid_d = accept;
        if (accept) begin
          main_imm_d = dec_imm;
          main_fmt_d = dec_fmt;
          main_ill_d = dec_ill;
          main_tag_d = in_tag;
        end
      end else if (accept && SKID_EN) begin
        skid_valid_d = 1'b1;
        skid_imm_d   = dec_imm;
        skid_fmt_d   = dec_fmt;
        skid_ill_d   = dec_ill;
        skid_tag_d   = in_tag;
      end
      in_ready_d = !skid_valid_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_fmt_q   <= FMT_NONE;
      main_ill_q   <= 1'b0;
      main_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_NONE;
      skid_ill_q   <= 1'b0;
      skid_tag_q   <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_fmt_q   <= main_fmt_d;
      main_ill_q   <= main_ill_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_ill_q   <= skid_ill_d;
      skid_tag_q   <= skid_tag_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_imm     = main_imm_q;
  assign out_fmt     = main_fmt_q;
  assign out_illegal = main_ill_q;
  assign out_tag     = main_tag_q;

endmodule
